// File: rtl/ahb_i2c_pkg.sv
// ahb_i2c_pkg: shared AHB encodings, slave FSM states and transfer check
package ahb_i2c_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // A transfer is usable by the byte-wide core only up to word size and word aligned
    function automatic logic xfer_ok(input logic [2:0] size, input logic [1:0] addr_lo);
        return (size <= HSIZE_WORD) && (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/ahb_slave_timer.sv
// ahb_slave_timer: counts enabled cycles and flags the last allowed one
module ahb_slave_timer
    import ahb_i2c_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic hclk,
    input  logic hreset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // count access cycles from zero; any non-access cycle clears
    always_ff @(posedge hclk) begin
        if (hreset || clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ahb_i2c_slave_if.sv
// ahb_i2c_slave_if: AHB slave bridging word accesses onto a byte-wide I2C core register port
module ahb_i2c_slave_if
    import ahb_i2c_pkg::*;
#(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic [AWIDTH-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [DWIDTH-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic [1:0]        hresp,
    output logic [DWIDTH-1:0] hrdata,
    output logic [2:0]        reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_stb,
    input  logic [7:0]        reg_rdata,
    input  logic              ack
);

    state_e state, nxt;
    logic   take, good, expired, in_access;
    state_e accept_nxt;
    logic   unused_bits;

    assign unused_bits = ^{haddr[AWIDTH-1:5], hwdata[DWIDTH-1:8]};

    assign take       = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign good       = xfer_ok(hsize, haddr[1:0]);
    assign accept_nxt = take ? (good ? ST_ACCESS : ST_ERR1) : ST_IDLE;
    assign in_access  = (state == ST_ACCESS);
    assign reg_stb    = in_access;
    assign reg_wdata  = hwdata[7:0];

    ahb_slave_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .hclk    (hclk),
        .hreset  (hreset),
        .clear   (!in_access),
        .enable  (in_access),
        .expired (expired)
    );

    // next state and bus response; ack beats an expiring timer
    always_comb begin
        nxt       = ST_IDLE;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state)
            ST_IDLE, ST_DONE: nxt = accept_nxt;
            ST_ACCESS: begin
                hreadyout = 1'b0;
                nxt       = ack ? ST_DONE : (expired ? ST_ERR1 : ST_ACCESS);
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                nxt       = ST_ERR2;
            end
            ST_ERR2: begin
                hresp = HRESP_ERROR;
                nxt   = accept_nxt;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // state, latched core address/direction and captured read byte
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= ST_IDLE;
            hrdata   <= '0;
            reg_addr <= '0;
            reg_we   <= 1'b0;
        end else begin
            state <= nxt;
            if (hreadyout && take && good) begin
                reg_addr <= haddr[4:2];
                reg_we   <= hwrite;
            end
            if (in_access && ack && !reg_we)
                hrdata <= {{(DWIDTH-8){1'b0}}, reg_rdata};
        end
    end

endmodule

// File: tb/tb_ahb_i2c_slave_if.sv
// tb_ahb_i2c_slave_if: directed AHB transfers checked by response and core-side scoreboards
module tb_ahb_i2c_slave_if;

    localparam int TMO = 16;

    typedef struct {
        logic [2:0] addr;
        logic       we;
        logic [7:0] wd;
        logic [7:0] rd;
        int         dly;
        int         len;
    } core_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          waits;
    } resp_t;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] hwdata = '0;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic [2:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic        reg_stb;
    logic [7:0]  reg_rdata = '0;
    logic        ack = 1'b0;

    core_t       cq[$];
    resp_t       rq[$];
    logic [31:0] exp_rd = '0;
    bit          dph = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    ahb_i2c_slave_if #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(TMO)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hreadyout),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_stb   (reg_stb),
        .reg_rdata (reg_rdata),
        .ack       (ack)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one address phase, queue its expectations, then drive its write data
    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [7:0] rd, input int dly,
                        input logic [1:0] tr, input bit rst_mid);
        bit valid;
        int n;
        valid = (sz <= 3'b010) && (a[1:0] == 2'b00);
        hsel = 1'b1; haddr = a; hwrite = w; hsize = sz; htrans = tr;
        if (tr[1]) begin
            if (valid) begin
                cq.push_back('{a[4:2], w, wd[7:0], rd, dly, rst_mid ? 1 : (dly < 0 ? TMO : dly + 1)});
                if (!rst_mid) begin
                    if (!w && dly >= 0) exp_rd = {24'h0, rd};
                    rq.push_back('{dly < 0 ? 2'b01 : 2'b00, exp_rd, dly < 0 ? TMO + 1 : dly + 1});
                end
            end else begin
                rq.push_back('{2'b01, exp_rd, 1});
            end
        end
        n = 0;
        do begin
            @(negedge hclk);
            n++;
        end while (!hreadyout && n < 200);
        if (!hreadyout) chk("accept_timeout", 32'(hreadyout), 32'h1);
        if (!tr[1]) begin
            chk("idle_ready", 32'(hreadyout), 32'h1);
            chk("idle_resp", 32'(hresp), 32'h0);
        end
        @(posedge hclk);
        #1;
        hwdata = wd; hsel = 1'b0; htrans = 2'b00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || cq.size() != 0 || dph) && n < 200) begin
            @(posedge hclk);
            #1;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'(rq.size() + cq.size()), 32'h0);
        repeat (2) @(posedge hclk);
        #1;
    endtask

    // Core model: drives ack/read data, checks each strobe burst against the queue head
    initial begin
        core_t ce;
        int sc;
        sc = 0;
        forever begin
            @(negedge hclk);
            if (reg_stb) begin
                if (sc == 0) begin
                    if (cq.size() == 0) begin
                        chk("stb_unexpected", 32'(reg_stb), 32'h0);
                    end else begin
                        ce = cq[0];
                        reg_rdata = ce.rd;
                        chk("reg_addr", 32'(reg_addr), 32'(ce.addr));
                        chk("reg_we", 32'(reg_we), 32'(ce.we));
                        if (ce.we) chk("reg_wdata", 32'(reg_wdata), 32'(ce.wd));
                    end
                end
                ack = (cq.size() != 0) && (sc == ce.dly);
                sc++;
            end else begin
                ack = 1'b0;
                if (sc != 0 && cq.size() != 0) begin
                    ce = cq.pop_front();
                    chk("stb_len", 32'(sc), 32'(ce.len));
                end
                sc = 0;
            end
        end
    end

    // Bus monitor: tracks each data phase and compares it on completion
    initial begin
        resp_t re;
        int w;
        logic [1:0] lr;
        w = 0;
        lr = 2'b00;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                dph = 0;
            end else begin
                if (dph) begin
                    if (!hreadyout) begin
                        w++;
                        lr = hresp;
                    end else begin
                        if (rq.size() == 0) begin
                            chk("resp_unexpected", 32'(rq.size()), 32'h1);
                        end else begin
                            re = rq.pop_front();
                            chk("hresp", 32'(hresp), 32'(re.resp));
                            chk("wait_cycles", 32'(w), 32'(re.waits));
                            chk("first_resp", 32'(lr), 32'(re.resp));
                            chk("hrdata", hrdata, re.rdata);
                        end
                        dph = 0;
                    end
                end
                if (!dph && hsel && hreadyout && htrans[1]) begin
                    dph = 1;
                    w = 0;
                    lr = 2'b00;
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge hclk);
        #1;
        @(negedge hclk);
        chk("rst_ready", 32'(hreadyout), 32'h1);
        chk("rst_resp", 32'(hresp), 32'h0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_reg_addr", 32'(reg_addr), 32'h0);
        chk("rst_reg_we", 32'(reg_we), 32'h0);
        chk("rst_stb", 32'(reg_stb), 32'h0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        // IDLE and BUSY: zero-wait OKAY, no core access
        xfer(32'h08, 1'b1, 3'b010, 32'h0, 8'h00, 0, 2'b00, 0);
        xfer(32'h08, 1'b1, 3'b010, 32'h0, 8'h00, 0, 2'b01, 0);
        drain();
        // write with one-cycle ack delay, then read with immediate ack
        xfer(32'h08, 1'b1, 3'b010, 32'h0000_00A5, 8'h00, 1, 2'b10, 0);
        drain();
        xfer(32'h10, 1'b0, 3'b010, 32'h0, 8'h3C, 0, 2'b10, 0);
        drain();
        // ack on the last allowed cycle wins over timeout
        xfer(32'h00, 1'b0, 3'b000, 32'h0, 8'h99, TMO - 1, 2'b11, 0);
        drain();
        // no ack: timeout error, hrdata holds
        xfer(32'h14, 1'b0, 3'b010, 32'h0, 8'h11, -1, 2'b10, 0);
        drain();
        // invalid size and misaligned address
        xfer(32'h00, 1'b0, 3'b011, 32'h0, 8'h00, 0, 2'b10, 0);
        drain();
        xfer(32'h02, 1'b1, 3'b010, 32'h0, 8'h00, 0, 2'b10, 0);
        drain();
        // back-to-back write then read, second accepted in DONE
        xfer(32'h04, 1'b1, 3'b010, 32'h0000_005E, 8'h00, 0, 2'b10, 0);
        xfer(32'h0C, 1'b0, 3'b010, 32'h0, 8'hC3, 2, 2'b11, 0);
        drain();
        // error then read accepted in ERR2
        xfer(32'h02, 1'b0, 3'b010, 32'h0, 8'h00, 0, 2'b10, 0);
        xfer(32'h18, 1'b0, 3'b010, 32'h0, 8'h6B, 0, 2'b10, 0);
        drain();
        // reset during ACCESS abandons the transfer
        xfer(32'h1C, 1'b1, 3'b010, 32'h0000_0042, 8'h00, -1, 2'b10, 1);
        hreset = 1'b1;
        @(negedge hclk);
        @(negedge hclk);
        chk("rstmid_stb", 32'(reg_stb), 32'h0);
        chk("rstmid_ready", 32'(hreadyout), 32'h1);
        chk("rstmid_resp", 32'(hresp), 32'h0);
        chk("rstmid_hrdata", hrdata, 32'h0);
        exp_rd = '0;
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        xfer(32'h1C, 1'b0, 3'b010, 32'h0, 8'h77, 1, 2'b10, 0);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
